// File: rtl/rv32i_pkg.sv
// Shared RV32I core-side definitions.
//   bridge_state_e : memory-bridge FSM states
//   core_size_e    : core_size access-width encoding
//   is_misaligned  : alignment rule for a (size, address[1:0]) pair
package rv32i_pkg;

  localparam int unsigned TMO_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESP
  } bridge_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE    = 2'b00,
    SZ_HALF    = 2'b01,
    SZ_WORD    = 2'b10,
    SZ_ILLEGAL = 2'b11
  } core_size_e;

  function automatic logic is_misaligned(input core_size_e size, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = addr_lo[0];
      SZ_WORD: mis = (addr_lo != 2'b00);
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/morv_mem_bridge_if.sv
// Bus bundles for morv_mem_bridge.
//   morv_core_if : core request/response (master = core, slave = bridge)
//     core_valid, core_address[32], core_write, core_wdata[32], core_wstrb[4],
//     core_size[2] -> ; <- core_rdata[32], core_ready, core_error
//   morv_mem_if  : memory bus (master = bridge, slave = memory)
//     mem_req, mem_we, mem_addr[32], mem_wdata[32], mem_wstrb[4] -> ;
//     <- mem_gnt, mem_rvalid, mem_rdata[32], mem_err
interface morv_core_if;
  logic        core_valid;
  logic [31:0] core_address;
  logic        core_write;
  logic [31:0] core_wdata;
  logic [3:0]  core_wstrb;
  logic [1:0]  core_size;
  logic [31:0] core_rdata;
  logic        core_ready;
  logic        core_error;

  modport master (
    output core_valid, core_address, core_write, core_wdata, core_wstrb, core_size,
    input  core_rdata, core_ready, core_error
  );
  modport slave (
    input  core_valid, core_address, core_write, core_wdata, core_wstrb, core_size,
    output core_rdata, core_ready, core_error
  );
endinterface

interface morv_mem_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_err;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_gnt, mem_rvalid, mem_rdata, mem_err
  );
  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_gnt, mem_rvalid, mem_rdata, mem_err
  );
endinterface

// File: rtl/morv_timeout_ctr.sv
// Saturating cycle counter with a programmable expiry limit.
//   clear   : synchronous clear (wins over enable)
//   enable  : count this cycle
//   limit   : number of enabled cycles until expiry
//   expired : this enabled cycle is the limit-th (or later) one
module morv_timeout_ctr #(
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  output logic             expired
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   cnt_inc;

  always_comb begin
    cnt_inc = {1'b0, cnt_q} + {{WIDTH{1'b0}}, 1'b1};
    cnt_d   = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !cnt_inc[WIDTH]) begin
      cnt_d = cnt_inc[WIDTH-1:0];
    end
    // Greater-or-equal keeps expiry asserted if a bus event pre-empted it once.
    expired = enable && (cnt_inc >= {1'b0, limit});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/morv_mem_bridge.sv
// Core-to-memory bridge: turns a held core request into one bus
// request/response pair, rejecting misaligned accesses locally and aborting
// with an error when the bus stalls for TIMEOUT_CYCLES cycles.
//   clk, rst_n : clock, async active-low reset
//   core       : morv_core_if.slave  (request in, one-cycle response out)
//   mem        : morv_mem_if.master  (req/gnt address phase, rvalid response)
module morv_mem_bridge
  import rv32i_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] RESET_RDATA    = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  morv_core_if.slave  core,
  morv_mem_if.master  mem
);

  bridge_state_e state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic          we_q, we_d;
  logic          err_q, err_d;
  core_size_e    size_q, size_d;
  logic          tmo_clear, tmo_enable, tmo_expired;

  morv_timeout_ctr #(.WIDTH(TMO_W)) u_tmo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (tmo_clear),
    .enable  (tmo_enable),
    .limit   (TMO_W'(TIMEOUT_CYCLES)),
    .expired (tmo_expired)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    wstrb_d    = wstrb_q;
    we_d       = we_q;
    err_d      = err_q;
    size_d     = size_q;
    tmo_clear  = 1'b0;
    tmo_enable = (state_q == ST_ADDR) || (state_q == ST_DATA);

    case (state_q)
      ST_IDLE: begin
        if (core.core_valid) begin
          addr_d  = core.core_address;
          we_d    = core.core_write;
          wdata_d = core.core_wdata;
          wstrb_d = core.core_wstrb;
          size_d  = core_size_e'(core.core_size);
          if (is_misaligned(core_size_e'(core.core_size), core.core_address[1:0])) begin
            state_d = ST_RESP;
            err_d   = 1'b1;
          end else begin
            state_d   = ST_ADDR;
            err_d     = 1'b0;
            tmo_clear = 1'b1;
          end
        end
      end
      ST_ADDR: begin
        // A same-cycle rvalid is not a response yet; only gnt matters here.
        if (mem.mem_gnt) begin
          state_d = ST_DATA;
        end else if (tmo_expired) begin
          state_d = ST_RESP;
          err_d   = 1'b1;
        end
      end
      ST_DATA: begin
        if (mem.mem_rvalid) begin
          if (!we_q) rdata_d = mem.mem_rdata;
          err_d   = mem.mem_err;
          state_d = ST_RESP;
        end else if (tmo_expired) begin
          state_d = ST_RESP;
          err_d   = 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= RESET_RDATA;
      wstrb_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= SZ_BYTE;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      wstrb_q <= wstrb_d;
      we_q    <= we_d;
      err_q   <= err_d;
      size_q  <= size_d;
    end
  end

  assign core.core_rdata = rdata_q;
  assign core.core_ready = (state_q == ST_RESP);
  assign core.core_error = (state_q == ST_RESP) && err_q;

  assign mem.mem_req   = (state_q == ST_ADDR);
  assign mem.mem_we    = (state_q == ST_ADDR) && we_q;
  assign mem.mem_addr  = {addr_q[31:2], 2'b00};
  assign mem.mem_wdata = wdata_q;
  assign mem.mem_wstrb = (state_q == ST_ADDR) ? wstrb_q : '0;

  // Only aligned, legal accesses may ever reach the bus.
  a_aligned_on_bus: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == ST_ADDR) |-> !is_misaligned(size_q, addr_q[1:0]));

endmodule

// File: tb/tb_morv_mem_bridge.sv
// Directed bench for morv_mem_bridge with a transaction-timeline model.
module tb_morv_mem_bridge;

  localparam int          LIMIT  = 8;
  localparam logic [31:0] RST_RD = 32'hCAFEF00D;
  localparam int          NEVER  = 1 << 30;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  morv_core_if cif ();
  morv_mem_if  mif ();

  morv_mem_bridge #(.TIMEOUT_CYCLES(LIMIT), .RESET_RDATA(RST_RD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .core  (cif),
    .mem   (mif)
  );

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          gnt_dly;
    bit          gnt_never;
    int          rv_dly;
    logic [31:0] rdata;
    logic        err;
    bit          stray;
  } txn_t;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  // Expected timeline of the transaction in flight (absolute cycle numbers).
  int          req_lo = -1, req_hi = -2, rdy_cyc = -1, rd_cyc = NEVER;
  logic        exp_err = 1'b0, exp_we = 1'b0;
  logic [31:0] exp_addr = '0, exp_wdata = '0;
  logic [3:0]  exp_wstrb = '0;
  logic [31:0] rd_old = RST_RD, rd_new = RST_RD;

  // Observations recorded by the compare process.
  int   req_total = 0;
  int   last_rdy = -1;
  logic last_err = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, exp);
  endtask

  function automatic logic [31:0] cur_rdata();
    return (cyc >= rd_cyc) ? rd_new : rd_old;
  endfunction

  function automatic txn_t mk(input logic [31:0] addr, input logic wr, input logic [1:0] size,
                              input logic [31:0] wdata, input logic [3:0] wstrb,
                              input int gnt_dly, input bit gnt_never, input int rv_dly,
                              input logic [31:0] rdata, input logic err, input bit stray);
    txn_t t;
    t.addr = addr; t.wr = wr; t.size = size; t.wdata = wdata; t.wstrb = wstrb;
    t.gnt_dly = gnt_dly; t.gnt_never = gnt_never; t.rv_dly = rv_dly;
    t.rdata = rdata; t.err = err; t.stray = stray;
    return t;
  endfunction

  // Request seen in cycle n: derive when the bus request, response and data must appear.
  task automatic model_plan(input txn_t t, input int n);
    bit mis;
    rd_old    = cur_rdata();
    rd_new    = rd_old;
    rd_cyc    = NEVER;
    mis       = (t.size == 2'b11) || (t.size == 2'b01 && t.addr[0]) ||
                (t.size == 2'b10 && t.addr[1:0] != 2'b00);
    exp_addr  = {t.addr[31:2], 2'b00};
    exp_we    = t.wr;
    exp_wdata = t.wdata;
    exp_wstrb = t.wstrb;
    if (mis) begin
      req_lo = -1; req_hi = -2; rdy_cyc = n + 1; exp_err = 1'b1;
    end else if (t.gnt_never || t.gnt_dly >= LIMIT) begin
      req_lo = n + 1; req_hi = n + LIMIT; rdy_cyc = n + 1 + LIMIT; exp_err = 1'b1;
    end else begin
      req_lo  = n + 1;
      req_hi  = n + 1 + t.gnt_dly;
      rdy_cyc = n + 2 + t.gnt_dly + t.rv_dly;
      exp_err = t.err;
      if (!t.wr) begin
        rd_new = t.rdata;
        rd_cyc = rdy_cyc;
      end
    end
  endtask

  task automatic compare_cycle();
    bit req_e;
    if (chk_en && rst_n) begin
      req_e = (cyc >= req_lo) && (cyc <= req_hi);
      chk("mem_req", 32'(mif.mem_req), 32'(req_e));
      if (req_e) begin
        chk("mem_addr", mif.mem_addr, exp_addr);
        chk("mem_we", 32'(mif.mem_we), 32'(exp_we));
        chk("mem_wdata", mif.mem_wdata, exp_wdata);
        chk("mem_wstrb", 32'(mif.mem_wstrb), 32'(exp_wstrb));
      end else begin
        chk("mem_we_off", 32'(mif.mem_we), 32'd0);
        chk("mem_wstrb_off", 32'(mif.mem_wstrb), 32'd0);
      end
      chk("core_ready", 32'(cif.core_ready), 32'(cyc == rdy_cyc));
      chk("core_error", 32'(cif.core_error), (cyc == rdy_cyc) ? 32'(exp_err) : 32'd0);
      chk("core_rdata", cif.core_rdata, cur_rdata());
      if (mif.mem_req) req_total++;
      if (cif.core_ready) begin
        last_rdy = cyc;
        last_err = cif.core_error;
      end
    end
  endtask

  // Starts in an IDLE cycle; returns in the IDLE cycle after the response.
  task automatic run_txn(input txn_t t, output int n, output int rdy_off, output int req_cnt);
    int  req0;
    bit  stray_k;
    n       = cyc;
    req0    = req_total;
    model_plan(t, n);
    rdy_off = rdy_cyc - n;
    cif.core_valid   = 1'b1;
    cif.core_address = t.addr;
    cif.core_write   = t.wr;
    cif.core_wdata   = t.wdata;
    cif.core_wstrb   = t.wstrb;
    cif.core_size    = t.size;
    for (int k = 1; k <= rdy_off; k++) begin
      @(posedge clk); #1;
      stray_k        = t.stray && !t.gnt_never && (k == 1 + t.gnt_dly);
      mif.mem_gnt    = !t.gnt_never && (k == 1 + t.gnt_dly);
      mif.mem_rvalid = stray_k || (!t.gnt_never && (k == 1 + t.gnt_dly + t.rv_dly));
      mif.mem_rdata  = stray_k ? 32'hBAD0BAD0 : t.rdata;
      mif.mem_err    = stray_k ? 1'b1 : t.err;
    end
    // core_valid stays high through the response cycle, as a real core would.
    @(posedge clk); #1;
    cif.core_valid = 1'b0;
    mif.mem_gnt    = 1'b0;
    mif.mem_rvalid = 1'b0;
    mif.mem_err    = 1'b0;
    req_cnt = req_total - req0;
  endtask

  task automatic idle(input int cycles, input bit stray);
    for (int k = 0; k < cycles; k++) begin
      mif.mem_rvalid = stray;
      mif.mem_rdata  = 32'h11111111;
      mif.mem_err    = stray;
      @(posedge clk); #1;
    end
    mif.mem_rvalid = 1'b0;
    mif.mem_err    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int   n, off, rq, prev_rdy;
    txn_t t;

    fork
      forever begin
        @(negedge clk);
        compare_cycle();
      end
    join_none

    cif.core_valid = 1'b0; cif.core_address = '0; cif.core_write = 1'b0;
    cif.core_wdata = '0;   cif.core_wstrb = '0;   cif.core_size = 2'b00;
    mif.mem_gnt = 1'b0; mif.mem_rvalid = 1'b0; mif.mem_rdata = '0; mif.mem_err = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdata", cif.core_rdata, RST_RD);
    chk("rst_ready", 32'(cif.core_ready), 32'd0);
    chk("rst_error", 32'(cif.core_error), 32'd0);
    chk("rst_req", 32'(mif.mem_req), 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;

    // Word load, minimum latency.
    t = mk(32'h100, 1'b0, 2'b10, 32'h0, 4'hF, 0, 1'b0, 1, 32'hDEADBEEF, 1'b0, 1'b0);
    run_txn(t, n, off, rq);
    chk("lw_model_lat", 32'(off), 32'd3);
    chk("lw_lat", 32'(last_rdy - n), 32'd3);
    chk("lw_rdata", cif.core_rdata, 32'hDEADBEEF);
    chk("lw_err", 32'(last_err), 32'd0);

    // Half store with grant delayed three cycles.
    t = mk(32'h102, 1'b1, 2'b01, 32'hABCD0000, 4'b1100, 3, 1'b0, 1, 32'h77777777, 1'b0, 1'b0);
    run_txn(t, n, off, rq);
    chk("sh_req_cycles", 32'(rq), 32'd4);
    chk("sh_lat", 32'(last_rdy - n), 32'd6);
    chk("sh_rdata_kept", cif.core_rdata, 32'hDEADBEEF);

    // Misaligned word, misaligned half, illegal size.
    t = mk(32'h103, 1'b0, 2'b10, 32'h0, 4'hF, 0, 1'b1, 0, 32'h0, 1'b0, 1'b0);
    run_txn(t, n, off, rq);
    chk("mis_w_lat", 32'(last_rdy - n), 32'd1);
    chk("mis_w_err", 32'(last_err), 32'd1);
    chk("mis_w_noreq", 32'(rq), 32'd0);
    t = mk(32'h101, 1'b0, 2'b01, 32'h0, 4'h3, 0, 1'b1, 0, 32'h0, 1'b0, 1'b0);
    run_txn(t, n, off, rq);
    chk("mis_h_noreq", 32'(rq), 32'd0);
    t = mk(32'h0, 1'b1, 2'b11, 32'h5, 4'hF, 0, 1'b1, 0, 32'h0, 1'b0, 1'b0);
    run_txn(t, n, off, rq);
    chk("ill_sz_err", 32'(last_err), 32'd1);

    // Byte load at an odd address is legal; bus address is word aligned.
    t = mk(32'h3, 1'b0, 2'b00, 32'h0, 4'b1000, 0, 1'b0, 1, 32'hA5A5A5A5, 1'b0, 1'b0);
    run_txn(t, n, off, rq);
    chk("lb_rdata", cif.core_rdata, 32'hA5A5A5A5);

    // rvalid coinciding with gnt must be ignored.
    t = mk(32'h400, 1'b0, 2'b10, 32'h0, 4'hF, 2, 1'b0, 2, 32'h0BADCAFE, 1'b0, 1'b1);
    run_txn(t, n, off, rq);
    chk("stray_gnt_rdata", cif.core_rdata, 32'h0BADCAFE);
    chk("stray_gnt_err", 32'(last_err), 32'd0);

    // Bus error on the response beat.
    t = mk(32'h300, 1'b0, 2'b10, 32'h0, 4'hF, 1, 1'b0, 2, 32'h12345678, 1'b1, 1'b0);
    run_txn(t, n, off, rq);
    chk("buserr_err", 32'(last_err), 32'd1);
    chk("buserr_lat", 32'(last_rdy - n), 32'd5);

    // Grant never arrives: abort after LIMIT cycles, then a late rvalid is dropped.
    t = mk(32'h500, 1'b0, 2'b10, 32'h0, 4'hF, 0, 1'b1, 0, 32'h0, 1'b0, 1'b0);
    run_txn(t, n, off, rq);
    chk("tmo_lat", 32'(last_rdy - n), 32'd9);
    chk("tmo_req_cycles", 32'(rq), 32'd8);
    chk("tmo_err", 32'(last_err), 32'd1);
    prev_rdy = last_rdy;
    idle(3, 1'b1);
    chk("tmo_late_rvalid", 32'(last_rdy), 32'(prev_rdy));
    chk("tmo_rdata_kept", cif.core_rdata, 32'h12345678);

    // Reset while waiting in DATA.
    t = mk(32'h200, 1'b0, 2'b10, 32'h0, 4'hF, 0, 1'b0, 20, 32'h0, 1'b0, 1'b0);
    n = cyc;
    model_plan(t, n);
    rdy_cyc = -1;
    rd_cyc  = NEVER;
    cif.core_valid = 1'b1; cif.core_address = 32'h200; cif.core_write = 1'b0; cif.core_size = 2'b10;
    @(posedge clk); #1;
    mif.mem_gnt = 1'b1;
    @(posedge clk); #1;
    mif.mem_gnt = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", 32'(mif.mem_req), 32'd0);
    chk("mid_rst_ready", 32'(cif.core_ready), 32'd0);
    chk("mid_rst_rdata", cif.core_rdata, RST_RD);
    cif.core_valid = 1'b0;
    rd_old = RST_RD; rd_new = RST_RD; req_lo = -1; req_hi = -2;
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Normal traffic after the reset.
    t = mk(32'h600, 1'b1, 2'b10, 32'h13579BDF, 4'hF, 0, 1'b0, 1, 32'hFFFFFFFF, 1'b0, 1'b0);
    run_txn(t, n, off, rq);
    chk("post_rst_sw_lat", 32'(last_rdy - n), 32'd3);
    chk("post_rst_sw_rdata", cif.core_rdata, RST_RD);
    t = mk(32'h604, 1'b0, 2'b10, 32'h0, 4'hF, 1, 1'b0, 1, 32'h2468ACE0, 1'b0, 1'b0);
    run_txn(t, n, off, rq);
    chk("post_rst_lw_lat", 32'(last_rdy - n), 32'd4);
    chk("post_rst_lw_rdata", cif.core_rdata, 32'h2468ACE0);

    idle(2, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
